// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: bundle between the pipeline datapath and the EX hazard
// controller.
//   master : pipeline side. It drives the ID instruction fields and the EX
//            branch info, and receives the stall/flush/forward controls and
//            the event counters.
//   slave  : hazard controller side, with the directions reversed.
interface ex_hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        ex_is_branch;
    logic        ex_branch_result;
    logic        stall_pc;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, ex_is_branch, ex_branch_result,
        input  stall_pc, stall_id, flush_id, flush_ex, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, ex_is_branch, ex_branch_result,
        output stall_pc, stall_id, flush_id, flush_ex, fwd_a, fwd_b,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: load-use stall, taken-branch flush and operand forwarding
// control for a 5-stage pipeline. It tracks the destination registers of the
// instructions in EX and MEM and selects the forwarding path for each EX
// operand.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   hif   : slave side of ex_hazard_ctrl_if. Inputs are the ID fields and the
//           EX branch info. Outputs are stall_pc/stall_id/flush_id/flush_ex
//           (combinational), fwd_a/fwd_b (registered) and stall_cnt/flush_cnt.
// The WB slot is simply where MEM lands after each edge. Nothing downstream
// of it affects hazards or forwarding, so it holds no storage here. The MEM
// slot keeps only the fields that forwarding reads.
module ex_hazard_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    ex_hazard_ctrl_if.slave  hif
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state_q, state_d;

    logic        ex_valid_q, ex_rw_q, ex_mr_q;
    logic [4:0]  ex_rd_q;
    logic        mem_valid_q, mem_rw_q;
    logic [4:0]  mem_rd_q;
    logic [1:0]  fwd_a_q, fwd_b_q;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    logic        id_live, taken, load_use;
    logic        stall_c, flush_id_c, flush_ex_c;

    // In FLUSH, the ID slot holds a wrong-path instruction and is ignored.
    assign id_live = hif.id_valid & (state_q == RUN);
    assign taken   = ex_valid_q & hif.ex_is_branch & hif.ex_branch_result
                   & (state_q == RUN);
    assign load_use = id_live & ex_valid_q & ex_mr_q & (ex_rd_q != 5'd0)
                    & ((hif.id_use_rs1 & (hif.id_rs1 == ex_rd_q))
                     | (hif.id_use_rs2 & (hif.id_rs2 == ex_rd_q)));

    // A taken branch wins over a load-use hazard.
    always_comb begin
        stall_c    = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        state_d    = RUN;
        if (taken) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end else if (load_use) begin
            stall_c    = 1'b1;
            flush_ex_c = 1'b1;
        end
        if (state_q == RUN && taken)
            state_d = FLUSH;
    end

    // EX/MEM result first, then MEM/WB. Register x0 never matches.
    function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs);
        if (!use_rs || rs == 5'd0)
            return 2'b00;
        if (ex_valid_q && ex_rw_q && ex_rd_q == rs)
            return 2'b01;
        if (mem_valid_q && mem_rw_q && mem_rd_q == rs)
            return 2'b10;
        return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ex_valid_q  <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_rd_q     <= 5'd0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_rd_q    <= 5'd0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_rd_q    <= ex_rd_q;
            if (id_live && !flush_ex_c) begin
                ex_valid_q <= 1'b1;
                ex_rw_q    <= hif.id_reg_write;
                ex_mr_q    <= hif.id_mem_read;
                ex_rd_q    <= hif.id_rd;
                fwd_a_q    <= fwd_sel(hif.id_use_rs1, hif.id_rs1);
                fwd_b_q    <= fwd_sel(hif.id_use_rs2, hif.id_rs2);
            end else begin
                ex_valid_q <= 1'b0;
                ex_rw_q    <= 1'b0;
                ex_mr_q    <= 1'b0;
                ex_rd_q    <= 5'd0;
                fwd_a_q    <= 2'b00;
                fwd_b_q    <= 2'b00;
            end
            if (stall_c && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (taken && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign hif.stall_pc  = stall_c;
    assign hif.stall_id  = stall_c;
    assign hif.flush_id  = flush_id_c;
    assign hif.flush_ex  = flush_ex_c;
    assign hif.fwd_a     = fwd_a_q;
    assign hif.fwd_b     = fwd_b_q;
    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl. Inputs change 1 time unit after a
// rising edge. Combinational flags are checked 1 unit after that, and
// registered outputs are checked 1 unit after the edge that loads them.
module tb_ex_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ex_hazard_ctrl_if hif ();

    ex_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare stall_pc, stall_id, flush_id and flush_ex as one 4-bit vector.
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {12'd0, hif.stall_pc, hif.stall_id, hif.flush_id, hif.flush_ex},
            {12'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        hif.id_valid     = v;
        hif.id_rs1       = rs1;
        hif.id_use_rs1   = u1;
        hif.id_rs2       = rs2;
        hif.id_use_rs2   = u2;
        hif.id_rd        = rd;
        hif.id_reg_write = rw;
        hif.id_mem_read  = mr;
    endtask

    task automatic set_br(input logic b, input logic r);
        hif.ex_is_branch     = b;
        hif.ex_branch_result = r;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_br(0, 0);
        #1;
        chk_flags("rst_flags", 4'b0000);
        chk("rst_fwd", {12'd0, hif.fwd_a, hif.fwd_b}, 16'd0);
        chk("rst_stall_cnt", hif.stall_cnt, 16'd0);
        chk("rst_flush_cnt", hif.flush_cnt, 16'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_flags("post_rst_flags", 4'b0000);

        // ADD x5 followed by ADD x6,x5,x7: forward from EX/MEM, no stall.
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        step();
        set_id(1, 5, 1, 7, 1, 6, 1, 0);
        #1;
        chk_flags("raw_nostall", 4'b0000);
        step();
        chk("raw_fwd_a", {14'd0, hif.fwd_a}, 16'd1);
        chk("raw_fwd_b", {14'd0, hif.fwd_b}, 16'd0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("bubble_fwd", {12'd0, hif.fwd_a, hif.fwd_b}, 16'd0);

        // LW x5, consumer reads x5 on rs2: one stall cycle, then MEM/WB forward.
        set_id(1, 1, 1, 0, 0, 5, 1, 1);
        step();
        set_id(1, 3, 1, 5, 1, 8, 1, 0);
        #1;
        chk_flags("lu_stall", 4'b1101);
        step();
        chk("lu_stall_cnt", hif.stall_cnt, 16'd1);
        chk_flags("lu_one_cycle", 4'b0000);
        step();
        chk("lu_fwd_b", {14'd0, hif.fwd_b}, 16'd2);
        chk("lu_fwd_a", {14'd0, hif.fwd_a}, 16'd0);
        chk("lu_stall_cnt2", hif.stall_cnt, 16'd1);

        // Writers to x5 in EX and MEM: the EX/MEM match wins. rs2 is not read.
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        step();
        set_id(1, 3, 1, 4, 1, 5, 1, 0);
        step();
        set_id(1, 5, 1, 5, 0, 10, 1, 0);
        step();
        chk("prio_fwd_a", {14'd0, hif.fwd_a}, 16'd1);
        chk("unused_rs2_fwd_b", {14'd0, hif.fwd_b}, 16'd0);

        // MEM-only writer of x10 (the consumer above is now in MEM after a bubble).
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_id(1, 10, 1, 0, 0, 11, 1, 0);
        step();
        chk("mem_fwd_a", {14'd0, hif.fwd_a}, 16'd2);

        // A taken branch while a LW-dependent pair sits in EX/ID: flush wins.
        set_id(1, 1, 1, 0, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 0, 0, 9, 1, 0);
        set_br(1, 1);
        #1;
        chk_flags("br_flush", 4'b0011);
        step();
        chk("br_flush_cnt", hif.flush_cnt, 16'd1);
        chk("br_stall_cnt", hif.stall_cnt, 16'd1);
        chk_flags("flush_state_flags", 4'b0000);
        step();
        // The squashed instruction (rd=9) must not have entered EX.
        set_br(0, 0);
        set_id(1, 9, 1, 0, 0, 12, 1, 0);
        step();
        chk("squash_fwd_a", {14'd0, hif.fwd_a}, 16'd0);
        chk("flush_cnt_hold", hif.flush_cnt, 16'd1);

        // LW x0 followed by a reader of x0: no stall and no forward.
        set_id(1, 1, 1, 0, 0, 0, 1, 1);
        step();
        set_id(1, 0, 1, 0, 1, 13, 1, 0);
        #1;
        chk_flags("x0_nostall", 4'b0000);
        step();
        chk("x0_fwd", {12'd0, hif.fwd_a, hif.fwd_b}, 16'd0);

        // Saturation of the stall counter.
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        set_id(1, 1, 1, 0, 0, 5, 1, 1);
        step();
        set_id(1, 0, 0, 5, 1, 14, 1, 0);
        #1;
        chk_flags("sat_stall", 4'b1101);
        step();
        chk("sat_stall_cnt", hif.stall_cnt, 16'hFFFF);

        // Enter FLUSH, then assert reset: every output clears immediately.
        set_id(1, 1, 1, 0, 0, 15, 1, 0);
        step();
        set_br(1, 1);
        step();
        chk("flush2_cnt", hif.flush_cnt, 16'd2);
        rst_n = 1'b0;
        #1;
        chk_flags("rst_mid_flags", 4'b0000);
        chk("rst_mid_fwd", {12'd0, hif.fwd_a, hif.fwd_b}, 16'd0);
        chk("rst_mid_stall_cnt", hif.stall_cnt, 16'd0);
        chk("rst_mid_flush_cnt", hif.flush_cnt, 16'd0);
        set_br(0, 0);
        set_id(1, 15, 1, 0, 0, 16, 1, 0);
        step();
        rst_n = 1'b1;
        step();
        chk_flags("rst_release_flags", 4'b0000);
        chk("rst_release_fwd", {14'd0, hif.fwd_a}, 16'd0);
        chk("rst_release_flush_cnt", hif.flush_cnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, release sampled on clock.
REQ-003 id_valid  input  1  ID stage holds a real instruction.
REQ-004 id_rs1, id_rs2  input  5 each  ID source register indices.
REQ-005 id_use_rs1, id_use_rs2  input  1 each  ID instruction reads the corresponding source.
REQ-006 id_rd  input  5  ID destination register index.
REQ-007 id_reg_write  input  1  ID instruction writes id_rd.
REQ-008 id_mem_read  input  1  ID instruction is a load.
REQ-009 ex_is_branch  input  1  EX instruction is a branch/jump.
REQ-010 ex_branch_result  input  1  EX branch condition from the ALU; taken = ex_is_branch & ex_branch_result & EX slot valid.
REQ-011 stall_pc, stall_id  output  1 each  hold PC and the IF/ID register this cycle.
REQ-012 flush_id  output  1  clear the IF/ID register at the next edge.
REQ-013 flush_ex  output  1  load a bubble into the ID/EX register at the next edge.
REQ-014 fwd_a, fwd_b  output  2 each  EX operand source: 00 register file, 01 EX/MEM alu_result, 10 MEM/WB write-back data; 11 never driven.
REQ-015 stall_cnt  output  16  saturating count of load-use stall cycles.
REQ-016 flush_cnt  output  16  saturating count of taken-branch flushes.

Function
REQ-017 Three internal slots, EX, MEM and WB, each hold {valid, rd, reg_write, mem_read}.
REQ-018 Every edge: WB<=MEM, MEM<=EX; EX<=ID fields if id_valid and no flush_ex, else EX<=bubble (valid=0).
REQ-019 Register index 0 never creates a hazard or forward match.
REQ-020 Load-use hazard (combinational): EX.valid & EX.mem_read & EX.rd!=0 & id_valid & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
REQ-021 On load-use hazard: stall_pc=stall_id=flush_ex=1, flush_id=0, for exactly one cycle.
REQ-022 On taken branch: flush_id=flush_ex=1, stall_pc=stall_id=0; taken branch has priority over a simultaneous load-use hazard.
REQ-023 FSM states RUN, FLUSH. RUN->FLUSH on taken branch; FLUSH->RUN unconditionally after one cycle.
REQ-024 In FLUSH: id_valid is treated as 0 (squashed wrong-path slot); no load-use hazard is raised; a branch in EX is a bubble and cannot be taken.
REQ-025 fwd_a/fwd_b are registered and updated at the same edge that moves ID into EX; they hold the selection for the instruction then in EX.
REQ-026 Forward selection at ID->EX transfer, per operand: 01 if the current EX slot is valid with reg_write and rd==rs!=0; else 10 if the current MEM slot matches likewise; else 00.
REQ-027 EX/MEM match has priority over MEM/WB match when both hit.
REQ-028 When a bubble is loaded into EX, fwd_a=fwd_b=00 at that edge.
REQ-029 An operand with id_use_rsX=0 yields fwd 00.
REQ-030 stall_cnt increments on each edge where the REQ-021 stall is active; it saturates at 0xFFFF.
REQ-031 flush_cnt increments on each edge where a taken branch is flushed; it saturates at 0xFFFF.
REQ-032 stall_pc, stall_id, flush_id and flush_ex are combinational from slot state, FSM state and inputs; no other combinational paths from inputs to outputs.

Reset
REQ-033 reset=0 clears all slot valid bits, sets FSM to RUN and sets fwd_a, fwd_b, stall_cnt and flush_cnt to 0, independent of clock.
REQ-034 During reset and in the first cycle after release, stall_pc, stall_id, flush_id and flush_ex are 0.
REQ-035 Reset asserted mid-stall or mid-FLUSH discards the pending operation; there is no residual stall or flush after release.

Verification
REQ-036 ADD x5 in ID, next cycle ADD x6,x5,x7 in ID -> dependent enters EX with fwd_a=01, fwd_b=00, no stall.
REQ-037 LW x5 in EX with consumer rs2=x5 in ID -> one cycle of stall_pc=stall_id=flush_ex=1; consumer then enters EX with fwd_b=10; stall_cnt=1.
REQ-038 Writers to x5 in both EX and MEM, consumer rs1=x5 -> fwd_a=01 (EX/MEM priority).
REQ-039 Taken branch in EX while a LW-dependent pair is in ID/EX -> flush_id=flush_ex=1 and stall=0; next cycle in FLUSH with no stall; flush_cnt=1.
REQ-040 Consumer of x0 after LW x0 -> no stall, fwd 00.
REQ-041 Force stall_cnt to 0xFFFF, then trigger another stall -> stall_cnt stays 0xFFFF; assert reset mid-FLUSH -> all outputs 0 immediately.
